ysyx_2022040010_mem_arb: RTL and testbench
==========================================

YSYX_2022040010_MEM_ARB -- requirements
Module: ysyx_2022040010_mem_arb

Interface
REQ-001 clk  in  1  clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_req_valid  in  1  fetch request pending; held until if_req_ready.
REQ-004 if_req_addr  in  64  fetch address.
REQ-005 if_req_ready  out  1  fetch request accepted this cycle.
REQ-006 if_resp_valid  out  1  fetch data valid; one-cycle pulse.
REQ-007 if_resp_data  out  64  fetch data.
REQ-008 mem_req_valid  in  1  load/store request pending; held until mem_req_ready.
REQ-009 mem_req_we  in  1  1=store, 0=load.
REQ-010 mem_req_addr  in  64  load/store address.
REQ-011 mem_req_wdata  in  64  store data.
REQ-012 mem_req_wmask  in  8  store byte mask.
REQ-013 mem_req_ready  out  1  load/store request accepted this cycle.
REQ-014 mem_resp_valid  out  1  load data / store ack valid; one-cycle pulse.
REQ-015 mem_resp_data  out  64  load data.
REQ-016 bus_req_valid  out  1  request to shared memory port.
REQ-017 bus_req_we / bus_req_addr / bus_req_wdata / bus_req_wmask  out  1/64/64/8  latched request fields.
REQ-018 bus_req_ready  in  1  memory port accepts request.
REQ-019 bus_resp_valid  in  1  memory port response (reads and writes).
REQ-020 bus_resp_data  in  64  memory port read data.
REQ-021 stall_req  out  1  pipeline stall request to hazard control.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT; exactly one transaction outstanding at any time.
REQ-023 IDLE, no valid request: stay IDLE, all readies 0.
REQ-024 IDLE, any valid request: grant one requester, assert its ready for that cycle only, latch owner and request fields, next state ISSUE.
REQ-025 Priority: MEM wins over IF, except when starve_cnt==3 and if_req_valid, then IF wins.
REQ-026 starve_cnt (2-bit) SHALL increment, saturating at 3, when MEM is granted while if_req_valid=1; clear to 0 when IF is granted; otherwise hold.
REQ-027 ISSUE: bus_req_valid=1 with latched fields; on bus_req_ready=1 next state WAIT, else hold ISSUE with fields stable.
REQ-028 WAIT: on bus_resp_valid=1, assert owner's resp_valid combinationally that cycle with resp_data=bus_resp_data; next state IDLE.
REQ-029 Minimum accept-to-response latency SHALL be 2 cycles (grant in cycle N, issue N+1, response earliest N+2); a new grant is possible in the cycle after response.
REQ-030 bus_resp_valid outside WAIT SHALL be ignored; bus_req_ready outside ISSUE SHALL be ignored.
REQ-031 For IF owner, bus_req_we=0 and bus_req_wmask=0; stores return mem_resp_valid on ack, data don't-care.
REQ-032 When not in ISSUE, all bus_req_* outputs SHALL be 0; non-owner resp_valid always 0; resp_data 0 when resp_valid=0.
REQ-033 stall_req = (state!=IDLE) | (if_req_valid & ~if_req_ready) | (mem_req_valid & ~mem_req_ready).

Reset
REQ-034 rst=1 SHALL force state IDLE, starve_cnt 0, latched fields 0, every output 0 on the next posedge.
REQ-035 Reset in ISSUE/WAIT abandons the transaction; no resp_valid is generated for it; late bus_resp_valid is ignored per REQ-030.

Structure
REQ-036 State encoding, owner encoding (OWN_IF/OWN_MEM), STARVE_MAX=3, AddrBus/RegBus widths SHALL live in the shared defines.v.
REQ-037 Grant selection SHALL be a combinational sub-module ysyx_2022040010_arb_pick (inputs: two valids, starve_cnt; output: grant one-hot).

Verification
REQ-038 Lone IF read addr 0x8000_0000, bus_req_ready=1, response 0x13 one cycle later -> if_req_ready at N, bus_req_valid at N+1, if_resp_valid with 0x13 at N+2.
REQ-039 IF and MEM valid same cycle in IDLE -> MEM granted first, IF granted on the following IDLE.
REQ-040 MEM valid continuously with IF valid for 4 grants -> MEM granted 3 times, IF on 4th, starve_cnt back to 0.
REQ-041 Store wmask 0x0F, bus_req_ready low 3 cycles -> bus fields stable through stall, stall_req=1 throughout, mem_resp_valid on ack.
REQ-042 rst asserted in WAIT, then bus_resp_valid=1 -> no resp_valid, all outputs 0, state IDLE.
REQ-043 Spurious bus_resp_valid in IDLE -> no resp_valid pulse, no state change.

Source files
------------

// File: rtl/ysyx_2022040010_mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_2022040010_mem_arb_pkg                                          |
// | Shared types and constants for the fetch/load-store memory arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ysyx_2022040010_mem_arb_pkg;

  localparam int ADDR_BUS_W = 64;
  localparam int REG_BUS_W  = 64;
  localparam int MASK_W     = 8;

  localparam logic [1:0] STARVE_MAX = 2'd3;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_IF  = 0;
  localparam int GNT_MEM = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_BUS_W-1:0] addr;
    logic [REG_BUS_W-1:0]  wdata;
    logic [MASK_W-1:0]     wmask;
  } bus_req_t;

  function automatic logic [1:0] starve_next(input logic [1:0] cnt);
    return (cnt == STARVE_MAX) ? cnt : cnt + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_2022040010_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_2022040010_arb_pick                                             |
// | Combinational grant selection: MEM first unless IF has starved.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_2022040010_arb_pick
  import ysyx_2022040010_mem_arb_pkg::*;
(
  input  logic       i_if_valid,
  input  logic       i_mem_valid,
  input  logic [1:0] i_starve_cnt,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_if_valid && (!i_mem_valid || (i_starve_cnt == STARVE_MAX))) begin
      o_grant[GNT_IF] = 1'b1;
    end else if (i_mem_valid) begin
      o_grant[GNT_MEM] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_2022040010_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_2022040010_mem_arb                                              |
// | Arbitrates fetch and load/store onto one memory port, one in flight. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_2022040010_mem_arb
  import ysyx_2022040010_mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid,
  input  logic [ADDR_BUS_W-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [REG_BUS_W-1:0]  if_resp_data,

  input  logic                  mem_req_valid,
  input  logic                  mem_req_we,
  input  logic [ADDR_BUS_W-1:0] mem_req_addr,
  input  logic [REG_BUS_W-1:0]  mem_req_wdata,
  input  logic [MASK_W-1:0]     mem_req_wmask,
  output logic                  mem_req_ready,
  output logic                  mem_resp_valid,
  output logic [REG_BUS_W-1:0]  mem_resp_data,

  output logic                  bus_req_valid,
  output logic                  bus_req_we,
  output logic [ADDR_BUS_W-1:0] bus_req_addr,
  output logic [REG_BUS_W-1:0]  bus_req_wdata,
  output logic [MASK_W-1:0]     bus_req_wmask,
  input  logic                  bus_req_ready,
  input  logic                  bus_resp_valid,
  input  logic [REG_BUS_W-1:0]  bus_resp_data,

  output logic                  stall_req
);

  arb_state_e r_state;
  arb_owner_e r_owner;
  bus_req_t   r_req;
  logic [1:0] r_starve_cnt;

  logic [1:0] w_grant;
  logic       w_idle;
  logic       w_issue;
  logic       w_resp;
  logic       w_if_gnt;
  logic       w_mem_gnt;

  ysyx_2022040010_arb_pick u_pick (
    .i_if_valid   (if_req_valid),
    .i_mem_valid  (mem_req_valid),
    .i_starve_cnt (r_starve_cnt),
    .o_grant      (w_grant)
  );

  // Everything is qualified with ~rst so a reset cycle never hands out a
  // grant or a response that the latched state would then forget.
  assign w_idle    = (r_state == ST_IDLE)  && !rst;
  assign w_issue   = (r_state == ST_ISSUE) && !rst;
  assign w_resp    = (r_state == ST_WAIT)  && !rst && bus_resp_valid;
  assign w_if_gnt  = w_idle && w_grant[GNT_IF];
  assign w_mem_gnt = w_idle && w_grant[GNT_MEM];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IF;
      r_req        <= '0;
      r_starve_cnt <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_if_gnt) begin
            r_owner       <= OWN_IF;
            r_req.we      <= 1'b0;
            r_req.addr    <= if_req_addr;
            r_req.wdata   <= '0;
            r_req.wmask   <= '0;
            r_starve_cnt  <= 2'd0;
            r_state       <= ST_ISSUE;
          end else if (w_mem_gnt) begin
            r_owner       <= OWN_MEM;
            r_req.we      <= mem_req_we;
            r_req.addr    <= mem_req_addr;
            r_req.wdata   <= mem_req_wdata;
            r_req.wmask   <= mem_req_wmask;
            if (if_req_valid) begin
              r_starve_cnt <= starve_next(r_starve_cnt);
            end
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus_req_ready) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_resp_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_req_ready  = w_if_gnt;
  assign mem_req_ready = w_mem_gnt;

  assign bus_req_valid = w_issue;
  assign bus_req_we    = w_issue ? r_req.we    : 1'b0;
  assign bus_req_addr  = w_issue ? r_req.addr  : '0;
  assign bus_req_wdata = w_issue ? r_req.wdata : '0;
  assign bus_req_wmask = w_issue ? r_req.wmask : '0;

  assign if_resp_valid  = w_resp && (r_owner == OWN_IF);
  assign mem_resp_valid = w_resp && (r_owner == OWN_MEM);
  assign if_resp_data   = if_resp_valid  ? bus_resp_data : '0;
  assign mem_resp_data  = mem_resp_valid ? bus_resp_data : '0;

  assign stall_req = !rst && ((r_state != ST_IDLE)
                   || (if_req_valid  && !if_req_ready)
                   || (mem_req_valid && !mem_req_ready));

endmodule
`default_nettype wire

// File: tb/tb_ysyx_2022040010_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_2022040010_mem_arb                                           |
// | Directed corner cases, then random traffic against a txn-level model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ysyx_2022040010_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_req_addr, if_resp_data;
  logic        mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [7:0]  mem_req_wmask;
  logic        bus_req_valid, bus_req_we, bus_req_ready, bus_resp_valid;
  logic [63:0] bus_req_addr, bus_req_wdata, bus_resp_data;
  logic [7:0]  bus_req_wmask;
  logic        stall_req;

  always #5 clk = ~clk;

  ysyx_2022040010_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .bus_req_valid(bus_req_valid), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask), .bus_req_ready(bus_req_ready),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .stall_req(stall_req)
  );

  wire [270:0] w_all_out = {if_req_ready, if_resp_valid, if_resp_data, mem_req_ready,
                            mem_resp_valid, mem_resp_data, bus_req_valid, bus_req_we,
                            bus_req_addr, bus_req_wdata, bus_req_wmask, stall_req};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Requester and memory-port model
  bit          if_pend, mem_pend, m_we;
  logic [63:0] if_a, m_a, m_wd;
  logic [7:0]  m_wm;
  bit          t_out, t_acc, t_mem, t_we, resp_now;
  logic [63:0] t_addr, t_wdata;
  logic [7:0]  t_wmask;
  int          starve, rdelay, prob, if_grants, mem_grants;
  bit          g_if, g_mem, exp_issue;
  logic [63:0] mem_model [logic [63:0]];

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 64'h5a5a_0000_1234_0000);
  endfunction

  function automatic logic [63:0] pick_addr();
    return 64'h8000_0000 + 64'($urandom_range(0, 7)) * 8;
  endfunction

  task automatic quiet();
    if_req_valid = 0; if_req_addr = '0;
    mem_req_valid = 0; mem_req_we = 0; mem_req_addr = '0; mem_req_wdata = '0; mem_req_wmask = '0;
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; quiet();
    bus_resp_valid = 1; bus_resp_data = 64'hdead;
    next_cycle(); next_cycle();
    @(negedge clk);
    check("reset_outputs_zero", 160'(|w_all_out), 160'(1'b0));
    next_cycle();
    rst = 0; quiet();

    // Lone fetch with fastest bus
    if_req_valid = 1; if_req_addr = 64'h8000_0000; bus_req_ready = 1;
    @(negedge clk);
    check("lone_if_ready_N", 160'(if_req_ready), 160'(1'b1));
    check("lone_bus_idle_N", 160'(bus_req_valid), 160'(1'b0));
    next_cycle(); if_req_valid = 0;
    @(negedge clk);
    check("lone_bus_valid_N1", 160'(bus_req_valid), 160'(1'b1));
    check("lone_bus_fields_N1", {bus_req_we, bus_req_addr, bus_req_wmask}, {1'b0, 64'h8000_0000, 8'h00});
    check("lone_stall_N1", 160'(stall_req), 160'(1'b1));
    next_cycle(); bus_req_ready = 0; bus_resp_valid = 1; bus_resp_data = 64'h13;
    @(negedge clk);
    check("lone_if_resp_N2", {if_resp_valid, if_resp_data}, {1'b1, 64'h13});
    check("lone_mem_resp_N2", 160'(mem_resp_valid), 160'(1'b0));
    next_cycle();
    // Response already consumed: the held bus_resp_valid is spurious in IDLE
    @(negedge clk);
    check("spurious_idle_no_resp", 160'({if_resp_valid, mem_resp_valid}), 160'(2'b00));
    next_cycle(); bus_resp_valid = 0;

    // Reset while waiting for a response, then a late response
    if_req_valid = 1; if_req_addr = 64'h8000_0040; bus_req_ready = 1;
    next_cycle(); if_req_valid = 0;
    next_cycle(); bus_req_ready = 0;
    @(negedge clk);
    check("rstwait_in_wait_stall", 160'(stall_req), 160'(1'b1));
    next_cycle(); rst = 1; bus_resp_valid = 1; bus_resp_data = 64'h77;
    @(negedge clk);
    check("rstwait_no_resp", 160'({if_resp_valid, mem_resp_valid}), 160'(2'b00));
    next_cycle(); rst = 0;
    @(negedge clk);
    check("rstwait_late_resp_outputs_zero", 160'(|w_all_out), 160'(1'b0));
    next_cycle(); bus_resp_valid = 0; if_req_valid = 1;
    @(negedge clk);
    check("rstwait_back_in_idle", 160'(if_req_ready), 160'(1'b1));
    next_cycle(); quiet();
    rst = 1; next_cycle(); rst = 0;

    // Random traffic; the first stretch keeps both requesters saturated
    if_pend = 0; mem_pend = 0; t_out = 0; t_acc = 0; starve = 0; rdelay = 0;
    if_grants = 0; mem_grants = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      prob = (cyc < 300) ? 100 : 40;
      if (!if_pend && $urandom_range(0, 99) < prob) begin
        if_pend = 1; if_a = pick_addr();
      end
      if (!mem_pend && $urandom_range(0, 99) < prob) begin
        mem_pend = 1; m_we = 1'($urandom_range(0, 1)); m_a = pick_addr();
        m_wd = {$urandom, $urandom}; m_wm = 8'($urandom_range(0, 255));
      end
      if_req_valid  = if_pend;
      if_req_addr   = if_pend ? if_a : {$urandom, $urandom};
      mem_req_valid = mem_pend;
      mem_req_we    = m_we; mem_req_addr = m_a; mem_req_wdata = m_wd; mem_req_wmask = m_wm;
      bus_req_ready = ($urandom_range(0, 2) != 0);
      resp_now = t_acc && (rdelay == 0);
      if (t_acc && rdelay > 0) rdelay--;
      bus_resp_valid = resp_now || (!t_acc && $urandom_range(0, 9) == 0);
      bus_resp_data  = (resp_now && !t_we) ? rd(t_addr) : {$urandom, $urandom};

      @(negedge clk);
      g_mem = !t_out && mem_pend && !(starve == 3 && if_pend);
      g_if  = !t_out && if_pend && !g_mem;
      exp_issue = t_out && !t_acc;
      check("rand_if_ready", 160'(if_req_ready), 160'(g_if));
      check("rand_mem_ready", 160'(mem_req_ready), 160'(g_mem));
      check("rand_bus_valid", 160'(bus_req_valid), 160'(exp_issue));
      if (exp_issue)
        check("rand_bus_fields", {bus_req_we, bus_req_addr, t_mem ? bus_req_wdata : 64'h0, bus_req_wmask},
              {t_we, t_addr, t_mem ? t_wdata : 64'h0, t_wmask});
      else
        check("rand_bus_zero", {bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wmask}, 160'(0));
      check("rand_if_resp", {if_resp_valid, if_resp_data},
            {resp_now && !t_mem, (resp_now && !t_mem) ? rd(t_addr) : 64'h0});
      check("rand_mem_resp_valid", 160'(mem_resp_valid), 160'(resp_now && t_mem));
      if (!(resp_now && t_mem && t_we))
        check("rand_mem_resp_data", 160'(mem_resp_data), 160'((resp_now && t_mem) ? rd(t_addr) : 64'h0));
      check("rand_stall", 160'(stall_req),
            160'(t_out || (if_pend && !g_if) || (mem_pend && !g_mem)));

      if (resp_now) begin
        if (t_mem && t_we) begin
          logic [63:0] w = rd(t_addr);
          for (int b = 0; b < 8; b++) if (t_wmask[b]) w[b*8 +: 8] = t_wdata[b*8 +: 8];
          mem_model[t_addr] = w;
        end
        t_out = 0; t_acc = 0;
      end else if (exp_issue && bus_req_ready) begin
        t_acc = 1; rdelay = $urandom_range(0, 2);
      end
      if (g_mem) begin
        if (if_pend) starve = (starve == 3) ? 3 : starve + 1;
        t_out = 1; t_mem = 1; t_we = m_we; t_addr = m_a; t_wdata = m_wd; t_wmask = m_wm;
        mem_pend = 0; mem_grants++;
      end
      if (g_if) begin
        starve = 0;
        t_out = 1; t_mem = 0; t_we = 0; t_addr = if_a; t_wdata = '0; t_wmask = '0;
        if_pend = 0; if_grants++;
      end
      next_cycle();
    end
    check("rand_if_grants_seen", 160'(if_grants > 50), 160'(1'b1));
    check("rand_mem_grants_seen", 160'(mem_grants > 50), 160'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
